uart_tx_frame_engine: RTL
=========================

// Module: uart_tx_frame_engine
// PURPOSE
//   Parametrised UART transmitter: the next generation of our UART TX path.
//   It adds a per-bit baud prescaler, a ready/valid input handshake and
//   1-or-2 stop bits, on top of optional even/odd parity.
//   It sits between the byte-producing datapath and the TX pin.
//   It latches one word plus its frame configuration on acceptance.
//   It then shifts the word out LSB-first as start, data, [parity], stop(s).
// PARAMETERS
//   WIDTH   8   data bits per frame (5..9)
//   DIV_W   16  width of the BAUD_DIV input (clock cycles per bit)
// PORTS
//   CLK         in   1        single clock; all state on rising edge
//   RST         in   1        asynchronous, active-high reset
//   BAUD_DIV    in   DIV_W    clock cycles per serial bit; 0 treated as 1
//   PAR_EN      in   1        1 = append parity bit
//   PAR_TYPE    in   1        0 = even parity, 1 = odd parity
//   STOP2       in   1        1 = two stop bits, 0 = one stop bit
//   P_DATA      in   WIDTH    word to send
//   DATA_VALID  in   1        producer has a word on P_DATA
//   READY       out  1        engine can accept a word this cycle
//   TX_OUT      out  1        serial line, registered, idles high
//   BUSY        out  1        registered, high while a frame is on the line
//   TX_DONE     out  1        one-cycle pulse at the end of the last stop bit
// BEHAVIOUR
//   Reset (async, any time, including mid-frame):
//     - TX_OUT=1, BUSY=0, READY=1, TX_DONE=0, state IDLE, counters 0.
//     - A frame in progress is abandoned; no TX_DONE is raised for it.
//   Handshake:
//     - A word is accepted on a rising edge where DATA_VALID & READY.
//     - READY = (state==IDLE); it is a registered value.
//     - DATA_VALID while READY=0 is ignored; the producer must hold the word.
//     - P_DATA, PAR_EN, PAR_TYPE, STOP2 and BAUD_DIV are captured at
//       acceptance. Later changes do not affect the current frame.
//   Bit timing:
//     - D = max(BAUD_DIV,1), as captured. Every bit occupies exactly D cycles.
//     - Down-counter cnt is loaded with D-1 at each bit start.
//     - The bit ends on the edge where cnt==0.
//   FSM: IDLE -> START -> DATA -> (PAR_EN ? PARITY : STOP) -> PARITY -> STOP -> IDLE
//     - IDLE:   TX_OUT=1. On accept go to START. On that same edge: TX_OUT<=0,
//               BUSY<=1, READY<=0.
//     - START:  TX_OUT=0 for D cycles.
//     - DATA:   TX_OUT=shreg[0] for D cycles per bit; shreg shifts right.
//               bit index counts 0..WIDTH-1, then leaves DATA.
//     - PARITY: TX_OUT = ^data_latched ^ PAR_TYPE_latched, for D cycles.
//     - STOP:   TX_OUT=1 for D cycles (STOP2 ? 2*D).
//               On the final edge: state<=IDLE, BUSY<=0, READY<=1, TX_DONE<=1.
//   Frame length: F = (1 + WIDTH + PAR_EN + 1 + STOP2) * D cycles.
//     - The accept edge is at t0; TX_DONE is high during cycle [t0+F, t0+F+1).
//   Back-to-back:
//     - The earliest next accept is the edge after the TX_DONE edge.
//     - This gives a minimum of 1 extra idle-high cycle between frames.
//   TX_DONE never asserts in the same cycle as READY=0.
//   BUSY is never low while TX_OUT carries start, data or parity.
// TESTING
//   1. WIDTH=8, D=4, PAR_EN=0, STOP2=0, P_DATA=8'hA5 -> TX_OUT=0,1,0,1,0,0,1,0,1,1
//      (4 cycles each); TX_DONE at t0+40; BUSY high for 40 cycles.
//   2. D=2, PAR_EN=1, PAR_TYPE=0, P_DATA=8'h07 -> parity bit=1.
//      Repeat with PAR_TYPE=1 -> parity bit=0. Frame length 22 cycles.
//   3. STOP2=1, D=3, P_DATA=8'hFF, PAR_EN=0 -> stop high for 6 cycles;
//      TX_DONE at t0+33.
//   4. Hold DATA_VALID high with 8'h11 then 8'h22 -> two frames, exactly 1 idle
//      cycle between them. Change P_DATA/STOP2 mid-frame -> no effect.
//   5. BAUD_DIV=0 -> identical to BAUD_DIV=1 (each bit 1 cycle, frame 10 cycles).
//   6. Assert RST mid-DATA (D=4, cycle 15) -> TX_OUT=1, BUSY=0 and READY=1
//      immediately; no TX_DONE. A new frame after release is correct.

Source files
------------

// File: rtl/uart_tx_frame_engine.sv
// ============================================================================
// Module      : uart_tx_frame_engine
// Description : UART transmitter with per-bit baud prescaler, ready/valid
//               input, optional even/odd parity and 1 or 2 stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame_engine #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [DIV_W-1:0] BAUD_DIV,
   input  logic             PAR_EN,
   input  logic             PAR_TYPE,
   input  logic             STOP2,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             DATA_VALID,
   output logic             READY,
   output logic             TX_OUT,
   output logic             BUSY,
   output logic             TX_DONE
);

   localparam int IDX_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               par_en_q, par_en_d;
   logic               par_type_q, par_type_d;
   logic               stop2_q, stop2_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;

   logic               w_bit_end;
   logic               w_parity;
   logic [DIV_W-1:0]   w_div_m1;

   assign w_bit_end = (cnt_q == '0);
   assign w_parity  = (^data_q) ^ par_type_q;
   // A divider of 0 behaves like 1, so the reload value saturates at 0.
   assign w_div_m1  = (BAUD_DIV == '0) ? '0 : BAUD_DIV - DIV_W'(1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         shreg_q    <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         stop2_q    <= 1'b0;
         idx_q      <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         stop2_q    <= stop2_d;
         idx_q      <= idx_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      shreg_d    = shreg_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      stop2_d    = stop2_q;
      idx_d      = idx_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      ready_d    = ready_q;
      done_d     = 1'b0;

      if (state_q != ST_IDLE && !w_bit_end) begin
         cnt_d = cnt_q - DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (DATA_VALID && ready_q) begin
               state_d    = ST_START;
               cnt_d      = w_div_m1;
               div_d      = w_div_m1;
               shreg_d    = P_DATA;
               data_d     = P_DATA;
               par_en_d   = PAR_EN;
               par_type_d = PAR_TYPE;
               stop2_d    = STOP2;
               idx_d      = '0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               ready_d    = 1'b0;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               cnt_d   = div_q;
               state_d = ST_DATA;
               tx_d    = shreg_q[0];
               shreg_d = shreg_q >> 1;
               idx_d   = '0;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               cnt_d = div_q;
               if (idx_q == IDX_W'(WIDTH - 1)) begin
                  idx_d = '0;
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = w_parity;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  tx_d    = shreg_q[0];
                  shreg_d = shreg_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) begin
               cnt_d   = div_q;
               state_d = ST_STOP;
               tx_d    = 1'b1;
               idx_d   = '0;
            end
         end
         ST_STOP: begin
            // idx counts stop bits; the last one is index 0 or 1.
            if (w_bit_end) begin
               cnt_d = div_q;
               if (idx_q == IDX_W'(stop2_q)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   assign READY   = ready_q;
   assign TX_OUT  = tx_q;
   assign BUSY    = busy_q;
   assign TX_DONE = done_q;

endmodule

`default_nettype wire
